// File: rtl/inertial_integrator_cal.sv
// Pitch integrator with complementary fusion against the AZ-derived pitch, and an
// on-demand calibration that averages 2^CAL_LOG2 gyro samples into the rate offset.
module inertial_integrator_cal #(
  parameter int             W           = 16,
  parameter int             INT_W       = 27,
  parameter int             OUT_SHIFT   = 11,
  parameter logic [W-1:0]   RT_OFFSET   = 16'h0050,
  parameter logic [W-1:0]   AZ_OFFSET   = 16'h00A0,
  parameter int             FUDGE       = 327,
  parameter int             FUSION_STEP = 1024,
  parameter int             CAL_LOG2    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld,
  input  logic         cal_start,
  input  logic [W-1:0] ptch_rt,
  input  logic [W-1:0] AZ,
  output logic [W-1:0] ptch,
  output logic         ptch_vld,
  output logic         cal_busy,
  output logic         cal_done
);

  localparam int PW = 2 * W;
  localparam int SW = INT_W + 2;
  localparam int AW = W + CAL_LOG2;

  localparam logic signed [PW-1:0]     FUDGE_V  = PW'(FUDGE);
  localparam logic signed [SW-1:0]     FUS_POS  = SW'(FUSION_STEP);
  localparam logic signed [SW-1:0]     FUS_NEG  = -FUS_POS;
  localparam logic signed [SW-1:0]     SAT_MAX  = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [SW-1:0]     SAT_MIN  = {3'b111, {(INT_W-1){1'b0}}};
  localparam logic [CAL_LOG2:0]        CAL_LAST = (CAL_LOG2+1)'((1 << CAL_LOG2) - 1);

  typedef enum logic {RUN, CAL} state_t;

  state_t                  state_reg,    state_next;
  logic signed [INT_W-1:0] ptch_int_reg, ptch_int_next;
  logic signed [W-1:0]     rt_off_reg,   rt_off_next;
  logic signed [AW-1:0]    cal_acc_reg,  cal_acc_next;
  logic [CAL_LOG2:0]       cal_cnt_reg,  cal_cnt_next;
  logic                    ptch_vld_reg, ptch_vld_next;
  logic                    cal_done_reg, cal_done_next;

  logic signed [W:0]       rt_comp;
  logic signed [PW-1:0]    az_diff;
  logic signed [PW-1:0]    ptch_acc;
  logic signed [PW-1:0]    ptch_ext;
  logic signed [SW-1:0]    sum;
  logic signed [INT_W-1:0] sum_sat;
  logic signed [AW-1:0]    cal_sum;

  assign ptch     = ptch_int_reg[OUT_SHIFT+W-1:OUT_SHIFT];
  assign ptch_vld = ptch_vld_reg;
  assign cal_busy = (state_reg == CAL);
  assign cal_done = cal_done_reg;

  assign rt_comp  = {ptch_rt[W-1], ptch_rt} - {rt_off_reg[W-1], rt_off_reg};
  assign az_diff  = {{W{AZ[W-1]}}, AZ} - {{W{AZ_OFFSET[W-1]}}, AZ_OFFSET};
  // Shifted product fits in 2W-13 bits, so comparing it sign-extended is the same compare.
  assign ptch_acc = (az_diff * FUDGE_V) >>> 13;
  assign ptch_ext = {{(PW-W){ptch[W-1]}}, ptch};

  assign sum = {{2{ptch_int_reg[INT_W-1]}}, ptch_int_reg}
             - {{(SW-W-1){rt_comp[W]}}, rt_comp}
             + ((ptch_acc > ptch_ext) ? FUS_POS : FUS_NEG);

  always_comb begin
    sum_sat = sum[INT_W-1:0];
    if (sum > SAT_MAX)      sum_sat = SAT_MAX[INT_W-1:0];
    else if (sum < SAT_MIN) sum_sat = SAT_MIN[INT_W-1:0];
  end

  assign cal_sum = cal_acc_reg + {{CAL_LOG2{ptch_rt[W-1]}}, ptch_rt};

  always_comb begin
    state_next    = state_reg;
    ptch_int_next = ptch_int_reg;
    rt_off_next   = rt_off_reg;
    cal_acc_next  = cal_acc_reg;
    cal_cnt_next  = cal_cnt_reg;
    ptch_vld_next = 1'b0;
    cal_done_next = cal_done_reg;

    // cal_start outranks a coincident vld in both states; that sample is dropped.
    if (cal_start) begin
      state_next    = CAL;
      ptch_int_next = '0;
      cal_acc_next  = '0;
      cal_cnt_next  = '0;
    end else if (vld) begin
      case (state_reg)
        RUN: begin
          ptch_int_next = sum_sat;
          ptch_vld_next = 1'b1;
        end
        CAL: begin
          if (cal_cnt_reg == CAL_LAST) begin
            // Floor-divide by taking the upper bits of the arithmetic sum.
            rt_off_next   = cal_sum[CAL_LOG2+W-1:CAL_LOG2];
            cal_done_next = 1'b1;
            state_next    = RUN;
            ptch_int_next = '0;
            cal_acc_next  = '0;
            cal_cnt_next  = '0;
          end else begin
            cal_acc_next = cal_sum;
            cal_cnt_next = cal_cnt_reg + 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      ptch_int_reg <= '0;
      rt_off_reg   <= RT_OFFSET;
      cal_acc_reg  <= '0;
      cal_cnt_reg  <= '0;
      ptch_vld_reg <= 1'b0;
      cal_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptch_int_reg <= ptch_int_next;
      rt_off_reg   <= rt_off_next;
      cal_acc_reg  <= cal_acc_next;
      cal_cnt_reg  <= cal_cnt_next;
      ptch_vld_reg <= ptch_vld_next;
      cal_done_reg <= cal_done_next;
    end
  end

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Bench for inertial_integrator_cal: directed scenarios plus random stimulus,
// checked against an integer-arithmetic model of the pitch/calibration behaviour.
module tb_inertial_integrator_cal;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        cal_start = 1'b0;
  logic [15:0] ptch_rt = '0;
  logic [15:0] AZ = '0;
  logic [15:0] ptch;
  logic        ptch_vld;
  logic        cal_busy;
  logic        cal_done;

  int passed = 0;
  int total  = 0;
  bit verbose = 1'b0;

  // Reference model state
  bit     m_cal, m_done, m_pvld;
  longint m_int, m_acc;
  int     m_cnt, m_off;

  always #5 clk = ~clk;

  inertial_integrator_cal dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .cal_start(cal_start),
    .ptch_rt(ptch_rt), .AZ(AZ), .ptch(ptch), .ptch_vld(ptch_vld),
    .cal_busy(cal_busy), .cal_done(cal_done)
  );

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] m_ptch16();
    return 16'(fdiv(m_int, 2048));
  endfunction

  task automatic model_reset();
    m_cal = 0; m_done = 0; m_pvld = 0;
    m_int = 0; m_acc = 0; m_cnt = 0; m_off = 80;
  endtask

  task automatic model_step(input int rt, input int az, input bit v, input bit cs);
    longint acc, s;
    int     p;
    if (cs) begin
      m_cal = 1; m_acc = 0; m_cnt = 0; m_int = 0; m_pvld = 0;
    end else if (!v) begin
      m_pvld = 0;
    end else if (m_cal) begin
      m_acc = m_acc + rt; m_cnt = m_cnt + 1; m_pvld = 0;
      if (m_cnt == 256) begin
        m_off = int'(fdiv(m_acc, 256));
        m_cal = 0; m_done = 1; m_int = 0; m_acc = 0; m_cnt = 0;
      end
    end else begin
      acc = fdiv(longint'(az - 160) * 327, 8192);
      p   = int'(fdiv(m_int, 2048));
      s   = m_int - longint'(rt - m_off) + ((acc > p) ? 1024 : -1024);
      if (s > 67108863)  s = 67108863;
      if (s < -67108864) s = -67108864;
      m_int  = s;
      m_pvld = 1;
    end
  endtask

  // Drives one clock cycle of inputs; returns at posedge+1 with the model advanced.
  task automatic send(input logic [15:0] rt, input logic [15:0] az, input bit v, input bit cs);
    ptch_rt = rt; AZ = az; vld = v; cal_start = cs;
    @(posedge clk); #1;
    vld = 1'b0; cal_start = 1'b0;
    model_step(int'($signed(rt)), int'($signed(az)), v, cs);
    if (verbose)
      $display("txn vld=%0b cal_start=%0b ptch_rt=%h AZ=%h -> ptch=%h ptch_vld=%0b busy=%0b done=%0b",
               v, cs, rt, az, ptch, ptch_vld, cal_busy, cal_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    total++;
    if (ptch !== 16'h0000 || ptch_vld !== 1'b0 || cal_busy !== 1'b0 || cal_done !== 1'b0)
      $display("FAIL reset ptch=%h vld=%b busy=%b done=%b required 0000/0/0/0", ptch, ptch_vld, cal_busy, cal_done);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_run_dither();
    logic [15:0] exp;
    verbose = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(16'h0050, 16'h00A0, 1, 0);
      exp = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      total++;
      if (ptch !== exp || ptch_vld !== 1'b1)
        $display("FAIL run_dither[%0d] ptch=%h vld=%b required ptch=%h vld=1", i, ptch, ptch_vld, exp);
      else passed++;
    end
    send(16'h0050, 16'h00A0, 0, 0);
    total++;
    if (ptch_vld !== 1'b0 || ptch !== 16'h0000)
      $display("FAIL run_idle ptch=%h vld=%b required 0000/0", ptch, ptch_vld);
    else passed++;
    verbose = 1'b0;
  endtask

  task automatic test_cal();
    send(16'h0000, 16'h00A0, 0, 1);
    total++;
    if (cal_busy !== 1'b1) $display("FAIL cal_enter busy=%b required 1", cal_busy);
    else passed++;
    for (int i = 0; i < 256; i++) begin
      send(16'h0064, 16'h00A0, 1, 0);
      if (i == 254) begin
        total++;
        if (cal_busy !== 1'b1 || ptch_vld !== 1'b0 || ptch !== 16'h0000)
          $display("FAIL cal_255 busy=%b vld=%b ptch=%h required 1/0/0000", cal_busy, ptch_vld, ptch);
        else passed++;
      end
    end
    total++;
    if (cal_busy !== 1'b0 || cal_done !== 1'b1 || ptch !== 16'h0000 || ptch_vld !== 1'b0)
      $display("FAIL cal_end busy=%b done=%b ptch=%h vld=%b required 0/1/0000/0", cal_busy, cal_done, ptch, ptch_vld);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      send(16'h0064, 16'h00A0, 1, 0);
      total++;
      if (ptch !== ((i % 2 == 0) ? 16'hFFFF : 16'h0000) || ptch !== m_ptch16())
        $display("FAIL cal_dither[%0d] ptch=%h required %h", i, ptch, m_ptch16());
      else passed++;
    end
  endtask

  task automatic test_cal_floor();
    send(16'h0000, 16'h00A0, 0, 1);
    for (int i = 0; i < 256; i++)
      send((i % 2 == 0) ? 16'hFFFD : 16'hFFFC, 16'h00A0, 1, 0);
    total++;
    if (cal_done !== 1'b1 || cal_busy !== 1'b0)
      $display("FAIL floor_end done=%b busy=%b required 1/0", cal_done, cal_busy);
    else passed++;
    // With offset -4 the first probe lands at 2047 (ptch 0), the second at 2048 (ptch 1).
    send(16'hF3FD, 16'h00A0, 1, 0);
    total++;
    if (ptch !== 16'h0000) $display("FAIL floor_probe1 ptch=%h required 0000", ptch);
    else passed++;
    send(16'hFBFB, 16'h00A0, 1, 0);
    total++;
    if (ptch !== 16'h0001) $display("FAIL floor_probe2 ptch=%h required 0001", ptch);
    else passed++;
  endtask

  task automatic test_reset_mid_cal();
    send(16'h0000, 16'h00A0, 0, 1);
    for (int i = 0; i < 100; i++) send(16'($urandom), 16'h00A0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (cal_busy !== 1'b0 || cal_done !== 1'b0 || ptch !== 16'h0000 || ptch_vld !== 1'b0)
      $display("FAIL mid_cal_reset busy=%b done=%b ptch=%h vld=%b required 0/0/0000/0", cal_busy, cal_done, ptch, ptch_vld);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0050, 16'h00A0, 1, 0);
    total++;
    if (ptch !== 16'hFFFF) $display("FAIL mid_cal_offset ptch=%h required ffff", ptch);
    else passed++;
    send(16'h0050, 16'h00A0, 1, 0);
  endtask

  task automatic test_saturation();
    int errs = 0;
    logic signed [15:0] prev;
    for (int i = 0; i < 2200; i++) begin
      send(16'h8000, 16'h00A0, 1, 0);
      if (ptch !== m_ptch16()) begin
        if (errs == 0) $display("FAIL sat_track[%0d] ptch=%h required %h", i, ptch, m_ptch16());
        errs++;
      end
    end
    total++;
    if (errs != 0 || ptch !== 16'h7FFF) $display("FAIL sat_hold ptch=%h required 7fff (%0d track errors)", ptch, errs);
    else passed++;
    errs = 0;
    prev = $signed(ptch);
    for (int i = 0; i < 200; i++) begin
      send(16'h7FFF, 16'h00A0, 1, 0);
      if ($signed(ptch) >= prev || ptch !== m_ptch16()) begin
        if (errs == 0) $display("FAIL sat_release[%0d] ptch=%h prev=%h required %h", i, ptch, prev, m_ptch16());
        errs++;
      end
      prev = $signed(ptch);
    end
    total++;
    if (errs != 0) $display("FAIL sat_monotonic errors=%0d required 0", errs);
    else passed++;
  endtask

  task automatic test_cal_start_vld();
    send(16'h1234, 16'h00A0, 1, 1);
    total++;
    if (cal_busy !== 1'b1 || ptch_vld !== 1'b0)
      $display("FAIL coincident_start busy=%b vld=%b required 1/0", cal_busy, ptch_vld);
    else passed++;
    for (int i = 0; i < 255; i++) send(16'h0010, 16'h00A0, 1, 0);
    total++;
    if (cal_busy !== 1'b1) $display("FAIL coincident_255 busy=%b required 1", cal_busy);
    else passed++;
    send(16'h0010, 16'h00A0, 1, 0);
    total++;
    if (cal_busy !== 1'b0 || cal_done !== 1'b1)
      $display("FAIL coincident_256 busy=%b done=%b required 0/1", cal_busy, cal_done);
    else passed++;
    send(16'h0010, 16'h00A0, 1, 0);
    total++;
    if (ptch !== 16'hFFFF) $display("FAIL coincident_offset ptch=%h required ffff", ptch);
    else passed++;
  endtask

  task automatic test_back_to_back_random();
    int errs = 0;
    bit v;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(3) != 0);
      send(16'($urandom), 16'($urandom), v, 0);
      if (ptch !== m_ptch16() || ptch_vld !== m_pvld || cal_busy !== m_cal || cal_done !== m_done) begin
        if (errs == 0)
          $display("FAIL random[%0d] ptch=%h vld=%b busy=%b done=%b required %h/%b/%b/%b",
                   i, ptch, ptch_vld, cal_busy, cal_done, m_ptch16(), m_pvld, m_cal, m_done);
        errs++;
      end
    end
    total++;
    if (errs != 0) $display("FAIL random_total errors=%0d required 0", errs);
    else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_dither();
    test_cal();
    test_cal_floor();
    test_reset_mid_cal();
    test_saturation();
    test_cal_start_vld();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
